// File: rtl/alu_operand_wb_pkg.sv
// cirno_pkg: ALU function codes, datapath width and the register-writing predicate
// shared by the operand/writeback stage and its register file.
package cirno_pkg;
    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        XOR = 4'b0001,
        OR  = 4'b0011,
        SUB = 4'b0100,
        ADD = 4'b0101,
        CMP = 4'b0110,
        SHR = 4'b0111,
        SH  = 4'b1010,
        SHL = 4'b1110
    } funct_e;

    function automatic logic writes_reg(input funct_e f);
        return f inside {ADD, SUB, SHL, SHR, XOR, OR, SH};
    endfunction
endpackage

// File: rtl/alu_operand_wb_regfile.sv
// cirno_regfile: NREG x DATA_W register file, two operand read ports, a debug read port
// and one synchronous write port; r0 is hardwired to zero.
module cirno_regfile #(
    parameter int NREG   = 8,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [DATA_W-1:0]       wd,
    input  logic [$clog2(NREG)-1:0] ra0,
    output logic [DATA_W-1:0]       rd0,
    input  logic [$clog2(NREG)-1:0] ra1,
    output logic [DATA_W-1:0]       rd1,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DATA_W-1:0]       dbg_data
);
    logic [DATA_W-1:0] r_regs [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (we && wa != '0) begin
            r_regs[wa] <= wd;
        end
    end

    assign rd0      = (ra0 == '0) ? '0 : r_regs[ra0];
    assign rd1      = (ra1 == '0) ? '0 : r_regs[ra1];
    assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
endmodule

// File: rtl/alu_operand_wb.sv
// alu_operand_wb: operand fetch and writeback around the registered 8-bit ALU.
// ALU_OPERAND_WB_BYPASS_EN selects forwarding of the in-flight result instead of a stall.
module alu_operand_wb #(
    parameter int NREG   = 8,
    parameter int DATA_W = cirno_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [3:0]              issue_funct,
    input  logic [$clog2(NREG)-1:0] issue_rd,
    input  logic [$clog2(NREG)-1:0] issue_rs,
    input  logic [$clog2(NREG)-1:0] issue_rt,
    input  logic                    issue_imm_sel,
    input  logic [DATA_W-1:0]       issue_imm,
    output logic                    alu_en,
    output logic [3:0]              alu_funct,
    output logic [DATA_W-1:0]       alu_x,
    output logic [DATA_W-1:0]       alu_y,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic                    alu_cmp,
    output logic                    cmp_flag,
    output logic                    illegal_funct,
    output logic [CNT_W-1:0]        retired,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DATA_W-1:0]       dbg_data
);
    import cirno_pkg::*;

    localparam int AW = $clog2(NREG);

    logic              r_wb_valid;
    logic [AW-1:0]     r_wb_rd;
    funct_e            r_wb_funct;
    logic              r_cmp_flag;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_retired;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic              w_wb_wr;
    logic              w_haz_x;
    logic              w_haz_y;

    cirno_regfile #(.NREG(NREG), .DATA_W(DATA_W)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (r_wb_valid && writes_reg(r_wb_funct)),
        .wa       (r_wb_rd),
        .wd       (alu_result),
        .ra0      (issue_rs),
        .rd0      (w_rs_data),
        .ra1      (issue_rt),
        .rd1      (w_rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // r0 never carries a live result, so it can never be a hazard source
    assign w_wb_wr = r_wb_valid && writes_reg(r_wb_funct) && r_wb_rd != '0;
    assign w_haz_x = w_wb_wr && issue_rs == r_wb_rd;
    assign w_haz_y = w_wb_wr && !issue_imm_sel && issue_rt == r_wb_rd;

`ifdef ALU_OPERAND_WB_BYPASS_EN
    assign issue_ready = 1'b1;
    assign alu_x       = w_haz_x ? alu_result : w_rs_data;
    assign alu_y       = issue_imm_sel ? issue_imm : (w_haz_y ? alu_result : w_rt_data);
`else
    assign issue_ready = !(w_haz_x || w_haz_y);
    assign alu_x       = w_rs_data;
    assign alu_y       = issue_imm_sel ? issue_imm : w_rt_data;
`endif

    assign alu_en        = issue_valid && issue_ready;
    assign alu_funct     = issue_funct;
    assign cmp_flag      = r_cmp_flag;
    assign illegal_funct = r_illegal;
    assign retired       = r_retired;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_funct <= ADD;
            r_cmp_flag <= 1'b0;
            r_illegal  <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_wb_valid <= alu_en;
            r_wb_rd    <= issue_rd;
            r_wb_funct <= funct_e'(issue_funct);
            r_illegal  <= r_wb_valid && !writes_reg(r_wb_funct) && r_wb_funct != CMP;
            if (r_wb_valid && r_wb_funct == CMP) r_cmp_flag <= alu_cmp;
            if (r_wb_valid) r_retired <= r_retired + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_operand_wb.sv
// tb_alu_operand_wb: randomized and directed checks of alu_operand_wb against an
// instruction-level architectural model, with a behavioural registered ALU attached.
module tb_alu_operand_wb;
    logic       clk = 0;
    logic       reset = 1;
    logic       issue_valid = 0;
    logic       issue_ready;
    logic [3:0] issue_funct = 0;
    logic [2:0] issue_rd = 0, issue_rs = 0, issue_rt = 0;
    logic       issue_imm_sel = 0;
    logic [7:0] issue_imm = 0;
    logic       alu_en;
    logic [3:0] alu_funct;
    logic [7:0] alu_x, alu_y;
    logic [7:0] alu_result = 0;
    logic       alu_cmp = 0;
    logic       cmp_flag, illegal_funct;
    logic [15:0] retired;
    logic [2:0] dbg_addr = 0;
    logic [7:0] dbg_data;

    int n_chk = 0, n_fail = 0;
    logic [7:0] m_regs [8];
    logic       m_cmp = 0;
    int         m_ret = 0, m_ill = 0, ill_seen = 0;
    int         prev_rd = 0;
    logic       prev_adj = 0;

`ifdef ALU_OPERAND_WB_BYPASS_EN
    localparam int STALL_CYC = 0;
`else
    localparam int STALL_CYC = 1;
`endif

    alu_operand_wb dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_funct(issue_funct), .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_imm_sel(issue_imm_sel), .issue_imm(issue_imm), .alu_en(alu_en),
        .alu_funct(alu_funct), .alu_x(alu_x), .alu_y(alu_y), .alu_result(alu_result),
        .alu_cmp(alu_cmp), .cmp_flag(cmp_flag), .illegal_funct(illegal_funct),
        .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y);
        case (f)
            4'b0101: return x + y;
            4'b0100: return x - y;
            4'b1110: return x << y[2:0];
            4'b0111: return x >> y[2:0];
            4'b0001: return x ^ y;
            4'b0011: return x | y;
            4'b1010: return (x << y[2:0]) | (x >> (4'd8 - {1'b0, y[2:0]}));
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic is_wr(input logic [3:0] f);
        return f == 4'h5 || f == 4'h4 || f == 4'hE || f == 4'h7 || f == 4'h1 || f == 4'h3 || f == 4'hA;
    endfunction

    always @(posedge clk) begin
        if (alu_en) begin
            alu_result <= alu_fn(alu_funct, alu_x, alu_y);
            alu_cmp    <= (alu_x == alu_y);
        end
        if (illegal_funct) ill_seen <= ill_seen + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_cmp = 0; m_ret = 0; prev_rd = 0; prev_adj = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        issue_valid = 0; reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            issue_valid = 0;
        end
        prev_adj = 0; prev_rd = 0;
    endtask

    task automatic issue(input logic [3:0] f, input int rd, input int rs, input int rt,
                         input logic isel, input logic [7:0] imm);
        int stalls;
        logic haz;
        logic [7:0] x, y;
        @(negedge clk);
        issue_valid = 1; issue_funct = f; issue_rd = 3'(rd); issue_rs = 3'(rs);
        issue_rt = 3'(rt); issue_imm_sel = isel; issue_imm = imm;
        #1;
        stalls = 0;
        while (!issue_ready && stalls < 4) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        haz = prev_adj && prev_rd != 0 && (rs == prev_rd || (!isel && rt == prev_rd));
        chk("stall_cycles", stalls, haz ? STALL_CYC : 0);
        chk("alu_en", alu_en, 1);
        x = m_regs[rs];
        y = isel ? imm : m_regs[rt];
        chk("alu_x", alu_x, x);
        chk("alu_y", alu_y, y);
        if (is_wr(f)) begin
            if (rd != 0) m_regs[rd] = alu_fn(f, x, y);
        end else if (f == 4'h6) m_cmp = (x == y);
        else m_ill++;
        m_ret++;
        prev_adj = 1;
        prev_rd = is_wr(f) ? rd : 0;
    endtask

    task automatic dbg(input string tag, input int a, input logic [7:0] exp);
        dbg_addr = 3'(a);
        #1;
        chk(tag, dbg_data, exp);
    endtask

    initial begin
        logic [3:0] fset [11] = '{4'h5, 4'h4, 4'hE, 4'h7, 4'h1, 4'h3, 4'h6, 4'hA, 4'hF, 4'h0, 4'h2};
        model_reset();
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        for (int i = 1; i < 8; i++) dbg("reset_reg", i, 8'h00);
        chk("reset_cmp", cmp_flag, 0);
        chk("reset_retired", retired, 0);
        chk("reset_illegal", illegal_funct, 0);
        chk("reset_ready", issue_ready, 1);

        issue(4'h5, 1, 0, 0, 1, 8'h05);
        idle(3);
        dbg("t2_r1", 1, 8'h05);
        chk("t2_retired", retired, 1);
        chk("t2_no_illegal", ill_seen, 0);

        issue(4'h5, 1, 0, 0, 1, 8'h03);
        issue(4'h4, 2, 1, 0, 1, 8'h01);
        idle(2);
        dbg("t3_r2", 2, 8'h02);

        issue(4'h5, 0, 0, 0, 1, 8'hFF);
        issue(4'h5, 3, 0, 0, 0, 8'h00);
        idle(2);
        dbg("t4_r3", 3, 8'h00);
        dbg("t4_r0", 0, 8'h00);

        issue(4'h5, 1, 0, 0, 1, 8'h07);
        idle(1);
        issue(4'h6, 5, 1, 1, 0, 8'h00);
        @(negedge clk); issue_valid = 0; #1;
        chk("t5_cmp_early", cmp_flag, 0);
        @(negedge clk); #1;
        chk("t5_cmp_set", cmp_flag, 1);
        dbg("t5_r5", 5, 8'h00);
        issue(4'hF, 6, 2, 3, 0, 8'h00);
        prev_adj = 0;
        @(negedge clk); issue_valid = 0; #1;
        chk("t5_ill_before", illegal_funct, 0);
        @(negedge clk); #1;
        chk("t5_ill_pulse", illegal_funct, 1);
        @(negedge clk); #1;
        chk("t5_ill_after", illegal_funct, 0);
        chk("t5_retired", retired, 16'(m_ret));
        dbg("t5_r6", 6, 8'h00);

        issue(4'h5, 4, 0, 0, 1, 8'h09);
        @(negedge clk); issue_valid = 0; reset = 1;
        @(negedge clk); reset = 0;
        model_reset();
        @(negedge clk); #1;
        dbg("t6_r4", 4, 8'h00);
        chk("t6_retired", retired, 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            issue(fset[$urandom_range(0, 10)], $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        idle(3);
        for (int i = 0; i < 8; i++) dbg("rand_reg", i, m_regs[i]);
        chk("rand_retired", retired, 16'(m_ret));
        chk("rand_cmp", cmp_flag, m_cmp);
        chk("rand_illegal_count", ill_seen, m_ill);

        do_reset();
        @(negedge clk);
        issue_valid = 1; issue_funct = 4'h5; issue_rd = 0; issue_rs = 0; issue_imm_sel = 1; issue_imm = 0;
        repeat (65535) @(negedge clk);
        issue_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("wrap_ffff", retired, 16'hFFFF);
        issue(4'h5, 0, 0, 0, 1, 8'h00);
        idle(2);
        #1;
        chk("wrap_zero", retired, 16'h0000);
        dbg("wrap_r0", 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
